// File: rtl/iot_sequencer.sv
// Sequences one PDP-8 IOT instruction onto the IOT distributor: address setup,
// skip sampling, timed IOP2/IOP4 pulses, and a one-cycle done back to the CPU.
module iot_sequencer #(
  parameter int PULSE_W = 1,
  parameter int GAP     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] instr,
  input  logic [7:0]  ac_in,
  input  logic        skip_flag,
  input  logic        clearacc,
  input  logic [7:0]  datain,
  output logic [2:0]  io_address,
  output logic        bit1_cp2,
  output logic        bit2_cp3,
  output logic [7:0]  dataout,
  output logic        busy,
  output logic        done,
  output logic        skip,
  output logic        ac_clear,
  output logic [7:0]  ac_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SKIP, S_IOP2, S_GAP2, S_IOP4, S_GAP4, S_DONE
  } state_t;

  localparam logic [7:0] PW_LAST  = 8'(PULSE_W - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  state_t      r_state;
  logic [11:0] r_instr;
  logic [7:0]  r_cnt;

  state_t      w_next;
  logic [11:0] w_src;
  logic        w_iot;
  logic [2:0]  w_addr;
  logic        w_cnt_zero;
  logic        w_active;

  // First enabled phase after the one just finished; disabled phases cost no cycles.
  function automatic state_t next_phase(input state_t finished, input logic [2:0] iop);
    if (finished == S_SETUP && iop[0])
      return S_SKIP;
    else if ((finished == S_SETUP || finished == S_SKIP) && iop[1])
      return S_IOP2;
    else if (finished != S_IOP4 && iop[2])
      return S_IOP4;
    else
      return S_DONE;
  endfunction

  // In IDLE the live instruction decides the first move; afterwards the latched copy does.
  assign w_src      = (r_state == S_IDLE) ? instr : r_instr;
  assign w_iot      = (w_src[11:9] == 3'b110);
  assign w_addr     = (w_src[8:6] == 3'b000) ? w_src[5:3] : 3'b000;
  assign w_cnt_zero = (r_cnt == 8'd0);
  assign w_active   = w_iot && (w_next != S_IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_iot ? S_SETUP : S_DONE;
      S_SETUP: w_next = next_phase(S_SETUP, w_src[2:0]);
      S_SKIP:  w_next = next_phase(S_SKIP, w_src[2:0]);
      S_IOP2:  if (w_cnt_zero) w_next = (GAP == 0) ? next_phase(S_IOP2, w_src[2:0]) : S_GAP2;
      S_GAP2:  if (w_cnt_zero) w_next = next_phase(S_IOP2, w_src[2:0]);
      S_IOP4:  if (w_cnt_zero) w_next = (GAP == 0) ? S_DONE : S_GAP4;
      S_GAP4:  if (w_cnt_zero) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it cycle for cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_instr    <= '0;
      r_cnt      <= '0;
      io_address <= '0;
      bit1_cp2   <= 1'b0;
      bit2_cp3   <= 1'b0;
      dataout    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      skip       <= 1'b0;
      ac_clear   <= 1'b0;
      ac_data    <= '0;
    end else begin
      r_state    <= w_next;
      io_address <= w_active ? w_addr : 3'b000;
      busy       <= w_active;
      bit1_cp2   <= (w_next == S_IOP2);
      bit2_cp3   <= (w_next == S_IOP4);
      done       <= (w_next == S_DONE);

      if (r_state == S_IDLE && start) begin
        r_instr  <= instr;
        dataout  <= ac_in;
        skip     <= 1'b0;
        ac_clear <= 1'b0;
        ac_data  <= '0;
      end
      if (r_state == S_SKIP)
        skip <= skip_flag;
      if (r_state == S_IOP2 && w_cnt_zero) begin
        ac_clear <= clearacc;
        ac_data  <= datain;
      end

      if (w_next != r_state) begin
        case (w_next)
          S_IOP2, S_IOP4: r_cnt <= PW_LAST;
          S_GAP2, S_GAP4: r_cnt <= GAP_LAST;
          default:        r_cnt <= 8'd0;
        endcase
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_iot_sequencer.sv
// Bench for iot_sequencer: three instances with different pulse/gap timing share
// one stimulus bus; a timeline model predicts every output of every instance.
module tb_iot_sequencer;

  localparam int NI  = 3;
  localparam int CLK = 10;

  function automatic int pw_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int gap_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 2;
    endcase
  endfunction

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #(CLK / 2) clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0] start_v;
  logic [11:0]   instr;
  logic [7:0]    ac_in;
  logic          skip_flag;
  logic          clearacc;
  logic [7:0]    datain;

  logic [2:0]    io_address [NI];
  logic [7:0]    dataout    [NI];
  logic [7:0]    ac_data    [NI];
  logic [NI-1:0] bit1, bit2, busy, done, skip, ac_clear;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    iot_sequencer #(.PULSE_W(pw_of(g)), .GAP(gap_of(g))) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_v[g]),
      .instr      (instr),
      .ac_in      (ac_in),
      .skip_flag  (skip_flag),
      .clearacc   (clearacc),
      .datain     (datain),
      .io_address (io_address[g]),
      .bit1_cp2   (bit1[g]),
      .bit2_cp3   (bit2[g]),
      .dataout    (dataout[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .skip       (skip[g]),
      .ac_clear   (ac_clear[g]),
      .ac_data    (ac_data[g])
    );
  end

  // scoreboard
  typedef struct {
    int         inst;
    int         n0;
    bit         iot;
    logic [2:0] addr;
    int         b1f;
    int         b2f;
    int         pw;
    int         done_off;
    logic       skip;
    logic       acc;
    logic [7:0] data;
    logic [7:0] dout;
  } exp_t;

  exp_t       exp_q[$];
  logic       hold_skip [NI];
  logic       hold_acc  [NI];
  logic [7:0] hold_data [NI];
  logic [7:0] hold_dout [NI];
  int         n_vec = 0;
  int         n_err = 0;
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", name, i, cyc, act, expv);
    end
  endtask

  task automatic clear_holds();
    for (int i = 0; i < NI; i++) begin
      hold_skip[i] = 1'b0;
      hold_acc[i]  = 1'b0;
      hold_data[i] = '0;
      hold_dout[i] = '0;
    end
  endtask

  task automatic check_idle(input int i);
    chk("idle_addr",  i, 32'(io_address[i]), 32'd0);
    chk("idle_bit1",  i, 32'(bit1[i]), 32'd0);
    chk("idle_bit2",  i, 32'(bit2[i]), 32'd0);
    chk("idle_done",  i, 32'(done[i]), 32'd0);
    chk("idle_busy",  i, 32'(busy[i]), 32'd0);
    chk("idle_skip",  i, 32'(skip[i]), 32'(hold_skip[i]));
    chk("idle_acclr", i, 32'(ac_clear[i]), 32'(hold_acc[i]));
    chk("idle_acdat", i, 32'(ac_data[i]), 32'(hold_data[i]));
    chk("idle_dout",  i, 32'(dataout[i]), 32'(hold_dout[i]));
  endtask

  task automatic check_op(input int i);
    exp_t e;
    int   k;
    bit   act, p1, p2;
    e   = exp_q[0];
    k   = cyc - e.n0;
    act = e.iot && k >= 1 && k <= e.done_off;
    p1  = e.b1f > 0 && k >= e.b1f && k < e.b1f + e.pw;
    p2  = e.b2f > 0 && k >= e.b2f && k < e.b2f + e.pw;
    chk("addr", i, 32'(io_address[i]), act ? 32'(e.addr) : 32'd0);
    chk("busy", i, 32'(busy[i]), 32'(act));
    chk("bit1", i, 32'(bit1[i]), 32'(p1));
    chk("bit2", i, 32'(bit2[i]), 32'(p2));
    chk("done", i, 32'(done[i]), 32'(k == e.done_off));
    chk("dout", i, 32'(dataout[i]), (k >= 1) ? 32'(e.dout) : 32'(hold_dout[i]));
    if (k < 1) begin
      chk("pre_skip",  i, 32'(skip[i]), 32'(hold_skip[i]));
      chk("pre_acdat", i, 32'(ac_data[i]), 32'(hold_data[i]));
    end
    if (k >= e.done_off) begin
      chk("res_skip",  i, 32'(skip[i]), 32'(e.skip));
      chk("res_acclr", i, 32'(ac_clear[i]), 32'(e.acc));
      chk("res_acdat", i, 32'(ac_data[i]), 32'(e.data));
      hold_skip[i] = e.skip;
      hold_acc[i]  = e.acc;
      hold_data[i] = e.data;
      hold_dout[i] = e.dout;
      void'(exp_q.pop_front());
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      for (int i = 0; i < NI; i++) begin
        if (exp_q.size() > 0 && exp_q[0].inst == i) check_op(i);
        else check_idle(i);
      end
    end
  end

  // reference: an operation is a timeline of offsets from the cycle start was raised
  function automatic exp_t model(input int inst, input int n0, input logic [11:0] w,
                                 input logic [7:0] ac, input logic sf, input logic ca,
                                 input logic [7:0] di);
    exp_t e;
    int   dev, ph, b0, b1, b2;
    dev = int'(w[8:3]);
    b0  = int'(w[0]);
    b1  = int'(w[1]);
    b2  = int'(w[2]);
    ph  = pw_of(inst) + gap_of(inst);
    e.inst = inst;
    e.n0   = n0;
    e.iot  = (w[11:9] == 3'b110);
    e.pw   = pw_of(inst);
    e.dout = ac;
    if (!e.iot) begin
      e.addr = 3'd0;
      e.b1f = 0; e.b2f = 0; e.done_off = 1;
      e.skip = 1'b0; e.acc = 1'b0; e.data = 8'h00;
    end else begin
      e.addr     = ((dev / 8) == 0) ? 3'(dev % 8) : 3'd0;
      e.b1f      = b1 ? 2 + b0 : 0;
      e.b2f      = b2 ? 2 + b0 + b1 * ph : 0;
      e.done_off = 2 + b0 + (b1 + b2) * ph;
      e.skip     = (b0 != 0) && sf;
      e.acc      = (b1 != 0) && ca;
      e.data     = (b1 != 0) ? di : 8'h00;
    end
    return e;
  endfunction

  // driver tasks
  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout cyc%0d: got %0d pending expected 0", cyc, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_op(input int inst, input logic [11:0] w, input logic [7:0] ac,
                        input logic sf, input logic ca, input logic [7:0] di, input bit inject);
    exp_t e;
    wait_idle();
    @(posedge clk); #1;
    skip_flag = sf;
    clearacc  = ca;
    datain    = di;
    instr     = w;
    ac_in     = ac;
    e = model(inst, cyc, w, ac, sf, ca, di);
    exp_q.push_back(e);
    start_v[inst] = 1'b1;
    @(posedge clk); #1;
    start_v[inst] = 1'b0;
    if (inject && e.iot && e.done_off >= 3) begin
      repeat (2) @(posedge clk);
      #1;
      instr = 12'(($urandom_range(0, 4095) & 12'o0777) | 12'o6000);
      ac_in = 8'($urandom_range(0, 255));
      start_v[inst] = 1'b1;
      @(posedge clk); #1;
      start_v[inst] = 1'b0;
    end
  endtask

  task automatic reset_mid_pulse();
    run_op(2, 12'o6012, 8'h5A, 1'b0, 1'b1, 8'h77, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    clear_holds();
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #(CLK * 60000);
    $display("FAIL watchdog cyc%0d: got no finish expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] w;
    int          op;
    reset     = 1'b1;
    start_v   = '0;
    instr     = '0;
    ac_in     = '0;
    skip_flag = 1'b0;
    clearacc  = 1'b0;
    datain    = '0;
    clear_holds();
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    reset_mid_pulse();
    run_op(2, 12'o6012, 8'h11, 1'b0, 1'b0, 8'h3E, 1'b0);
    run_op(0, 12'o6031, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0);
    run_op(0, 12'o6036, 8'h33, 1'b0, 1'b1, 8'hA5, 1'b0);
    run_op(1, 12'o6044, 8'h3C, 1'b1, 1'b1, 8'hFF, 1'b0);
    run_op(0, 12'o6736, 8'h44, 1'b1, 1'b1, 8'h99, 1'b1);
    run_op(0, 12'o7001, 8'h55, 1'b1, 1'b1, 8'h66, 1'b0);
    run_op(2, 12'o6017, 8'h66, 1'b1, 1'b1, 8'hC3, 1'b1);
    run_op(1, 12'o6000, 8'h77, 1'b1, 1'b1, 8'h12, 1'b0);

    for (int n = 0; n < 160; n++) begin
      op = $urandom_range(0, 7);
      if (op == 6) op = 7;
      if ($urandom_range(0, 4) != 0) op = 6;
      w[11:9] = 3'(op);
      w[8:6]  = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      w[5:3]  = 3'($urandom_range(0, 7));
      w[2:0]  = 3'($urandom_range(0, 7));
      run_op($urandom_range(0, NI - 1), w, 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
    end

    wait_idle();
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
